// File: rtl/ct_lsu_dcwp_pkg.sv
// Shared types for the LSU dcache-state tracker.
// State layout keeps {dirty, share, valid} in the low bits so array din merges line up.
package ct_lsu_dcwp_pkg;

    localparam int MAX_WAY_W = 2;

    localparam int DIRTY_BIT = 2;
    localparam int SHARE_BIT = 1;
    localparam int VALID_BIT = 0;

    typedef logic [MAX_WAY_W-1:0] dcwp_way_t;

    typedef struct packed {
        dcwp_way_t way;
        logic      dirty;
        logic      share;
        logic      valid;
    } dcwp_st_t;

    function automatic int unsigned dcwp_off(input int unsigned way);
        return 3 * way;
    endfunction

endpackage

// File: rtl/ct_lsu_dcwp_info_entry.sv
// One tracked LSU entry: stored index/tag, dcache-state snapshot, snoop logic.
// Alloc values are bypassed into the snoop compare so a coincident write is kept.
module ct_lsu_dcwp_info_entry
    import ct_lsu_dcwp_pkg::*;
#(
    parameter int WAY_NUM = 2,
    parameter int WAY_W   = 1,
    parameter int IDX_W   = 9,
    parameter int TAG_W   = 26
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_alloc,
    input  logic                   i_dealloc,
    input  logic [IDX_W-1:0]       i_alloc_idx,
    input  logic [TAG_W-1:0]       i_alloc_tag,
    input  logic                   i_alloc_sw,
    input  dcwp_st_t               i_alloc_st,
    input  logic [IDX_W-1:0]       i_dc_idx,
    input  logic                   i_tag_gwen,
    input  logic [WAY_NUM-1:0]     i_tag_wen,
    input  logic [WAY_NUM*TAG_W-1:0] i_tag_din,
    input  logic                   i_dirty_gwen,
    input  logic [3*WAY_NUM-1:0]   i_dirty_wen,
    input  logic [3*WAY_NUM-1:0]   i_dirty_din,
    output logic                   o_vld,
    output logic [WAY_W-1:0]       o_way,
    output logic                   o_valid,
    output logic                   o_share,
    output logic                   o_dirty,
    output logic                   o_update
);

    logic             r_vld;
    logic             r_sw;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    dcwp_st_t         r_st;
    logic             r_upd;

    logic             w_occ;
    logic             w_sw;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    dcwp_st_t         w_cur;
    dcwp_st_t         w_nxt;
    logic             w_idx_hit;
    logic [2:0]       w_sel_wen;
    logic [2:0]       w_sel_din;
    logic             w_rf_hit;
    dcwp_way_t        w_rf_way;
    logic [2:0]       w_rf_bits;
    logic             w_hit_upd;
    logic             w_sw_upd;
    logic             w_rf_upd;

    assign w_occ     = i_alloc | (r_vld & ~i_dealloc);
    assign w_sw      = i_alloc ? i_alloc_sw  : r_sw;
    assign w_idx     = i_alloc ? i_alloc_idx : r_idx;
    assign w_tag     = i_alloc ? i_alloc_tag : r_tag;
    assign w_cur     = i_alloc ? i_alloc_st  : r_st;
    assign w_idx_hit = (w_idx == i_dc_idx);

    always_comb begin
        w_sel_wen = '0;
        w_sel_din = '0;
        for (int unsigned w = 0; w < WAY_NUM; w++) begin
            if (w_cur.way == dcwp_way_t'(w)) begin
                w_sel_wen = i_dirty_wen[dcwp_off(w) +: 3];
                w_sel_din = i_dirty_din[dcwp_off(w) +: 3];
            end
        end
    end

    // Walk downwards so the lowest matching way is the one left standing.
    always_comb begin
        w_rf_hit  = 1'b0;
        w_rf_way  = '0;
        w_rf_bits = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (i_tag_wen[w] &&
                i_dirty_wen[dcwp_off(w) + VALID_BIT] &&
                i_dirty_din[dcwp_off(w) + VALID_BIT] &&
                (i_tag_din[w*TAG_W +: TAG_W] == w_tag)) begin
                w_rf_hit  = 1'b1;
                w_rf_way  = dcwp_way_t'(w);
                w_rf_bits = i_dirty_din[dcwp_off(w) +: 3];
            end
        end
    end

    assign w_hit_upd = w_occ & i_dirty_gwen & w_cur.valid & ~w_sw & w_idx_hit;
    assign w_sw_upd  = w_occ & i_dirty_gwen & w_sw & w_idx_hit;
    assign w_rf_upd  = w_occ & i_tag_gwen & ~w_sw & ~w_cur.valid
                     & w_idx_hit & w_rf_hit;

    always_comb begin
        w_nxt = w_cur;
        unique case (1'b1)
            (w_hit_upd | w_sw_upd): begin
                w_nxt[2:0] = (w_sel_wen & w_sel_din) | (~w_sel_wen & w_cur[2:0]);
            end
            w_rf_upd: begin
                w_nxt.way  = w_rf_way;
                w_nxt[2:0] = w_rf_bits;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= 1'b0;
            r_sw  <= 1'b0;
            r_idx <= '0;
            r_tag <= '0;
            r_st  <= '0;
            r_upd <= 1'b0;
        end else begin
            r_vld <= w_occ;
            r_st  <= w_nxt;
            r_upd <= w_hit_upd | w_sw_upd | w_rf_upd;
            if (i_alloc) begin
                r_sw  <= i_alloc_sw;
                r_idx <= i_alloc_idx;
                r_tag <= i_alloc_tag;
            end
        end
    end

    assign o_vld    = r_vld;
    assign o_way    = r_st.way[WAY_W-1:0];
    assign o_valid  = r_st.valid;
    assign o_share  = r_st.share;
    assign o_dirty  = r_st.dirty;
    assign o_update = r_upd;

endmodule

// File: rtl/ct_lsu_dcwp_info_track.sv
// Per-entry dcache-state tracker for LSU in-flight queue entries.
// Keeps each entry's way/valid/share/dirty coherent with tag and dirty array writes.
module ct_lsu_dcwp_info_track
    import ct_lsu_dcwp_pkg::*;
#(
    parameter  int ENTRY_NUM = 8,
    parameter  int WAY_NUM   = 2,
    parameter  int IDX_W     = 9,
    parameter  int PA_W      = 40,
    parameter  int TAG_W     = 26,
    localparam int WAY_W     = $clog2(WAY_NUM)
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    input  logic                     alloc_vld,
    input  logic [ENTRY_NUM-1:0]     alloc_ptr,
    input  logic [PA_W-1:0]          alloc_addr,
    input  logic                     alloc_sw_inst,
    input  logic [WAY_W-1:0]         alloc_dc_way,
    input  logic                     alloc_dc_valid,
    input  logic                     alloc_dc_share,
    input  logic                     alloc_dc_dirty,
    input  logic [ENTRY_NUM-1:0]     dealloc_vec,
    input  logic [IDX_W-1:0]         dcache_idx,
    input  logic                     dcache_tag_gwen,
    input  logic [WAY_NUM-1:0]       dcache_tag_wen,
    input  logic [WAY_NUM*TAG_W-1:0] dcache_tag_din,
    input  logic                     dcache_dirty_gwen,
    input  logic [3*WAY_NUM-1:0]     dcache_dirty_wen,
    input  logic [3*WAY_NUM-1:0]     dcache_dirty_din,
    output logic [ENTRY_NUM-1:0]     entry_vld,
    output logic [ENTRY_NUM*WAY_W-1:0] entry_dc_way,
    output logic [ENTRY_NUM-1:0]     entry_dc_valid,
    output logic [ENTRY_NUM-1:0]     entry_dc_share,
    output logic [ENTRY_NUM-1:0]     entry_dc_dirty,
    output logic [ENTRY_NUM-1:0]     entry_update
);

    logic [IDX_W-1:0] w_alloc_idx;
    logic [TAG_W-1:0] w_alloc_tag;
    dcwp_st_t         w_alloc_st;
    logic             w_unused_addr;

    assign w_alloc_idx   = alloc_addr[IDX_W+5:6];
    assign w_alloc_tag   = alloc_addr[PA_W-1:PA_W-TAG_W];
    assign w_unused_addr = ^alloc_addr[5:0];

    always_comb begin
        w_alloc_st       = '0;
        w_alloc_st.way   = dcwp_way_t'(alloc_dc_way);
        w_alloc_st.dirty = alloc_dc_dirty;
        w_alloc_st.share = alloc_dc_share;
        w_alloc_st.valid = alloc_dc_valid;
    end

    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
        ct_lsu_dcwp_info_entry #(
            .WAY_NUM (WAY_NUM),
            .WAY_W   (WAY_W),
            .IDX_W   (IDX_W),
            .TAG_W   (TAG_W)
        ) u_entry (
            .i_clk        (forever_cpuclk),
            .i_rst        (cpurst),
            .i_alloc      (alloc_vld & alloc_ptr[i]),
            .i_dealloc    (dealloc_vec[i]),
            .i_alloc_idx  (w_alloc_idx),
            .i_alloc_tag  (w_alloc_tag),
            .i_alloc_sw   (alloc_sw_inst),
            .i_alloc_st   (w_alloc_st),
            .i_dc_idx     (dcache_idx),
            .i_tag_gwen   (dcache_tag_gwen),
            .i_tag_wen    (dcache_tag_wen),
            .i_tag_din    (dcache_tag_din),
            .i_dirty_gwen (dcache_dirty_gwen),
            .i_dirty_wen  (dcache_dirty_wen),
            .i_dirty_din  (dcache_dirty_din),
            .o_vld        (entry_vld[i]),
            .o_way        (entry_dc_way[i*WAY_W +: WAY_W]),
            .o_valid      (entry_dc_valid[i]),
            .o_share      (entry_dc_share[i]),
            .o_dirty      (entry_dc_dirty[i]),
            .o_update     (entry_update[i])
        );
    end

endmodule
